// File: rtl/sys_defs.sv
// Shared scheduler definitions: functional-unit classes, widths and slot layout.
package sys_defs;

  typedef enum logic [2:0] {
    FU_ALU  = 3'd0,
    FU_LD   = 3'd1,
    FU_ST   = 3'd2,
    FU_MULT = 3'd3,
    FU_BR   = 3'd4
  } fu_name_t;

  localparam int FU_W  = 3;   // width of a req_fu element
  localparam int AGE_W = 4;   // saturating age counter width
  localparam int OCC_W = 4;   // multiplier occupancy counter (MULT_LAT <= 15)

  // Slot layout: ALU[NUM_ALU-1:0], LD, ST, MULT[NUM_MULT-1:0], BR
  function automatic int num_fu(input int na, input int nm);
    return na + nm + 3;
  endfunction
  function automatic int slot_ld(input int na);   return na;          endfunction
  function automatic int slot_st(input int na);   return na + 1;      endfunction
  function automatic int slot_mult(input int na); return na + 2;      endfunction
  function automatic int slot_br(input int na, input int nm);
    return na + nm + 2;
  endfunction

  // Constants for the default 3-ALU / 2-multiplier configuration
  localparam int DEF_NUM_ALU  = 3;
  localparam int DEF_NUM_MULT = 2;
  localparam int NUM_FU       = num_fu(DEF_NUM_ALU, DEF_NUM_MULT);
  localparam int SLOT_LD      = slot_ld(DEF_NUM_ALU);
  localparam int SLOT_ST      = slot_st(DEF_NUM_ALU);
  localparam int SLOT_MULT0   = slot_mult(DEF_NUM_ALU);
  localparam int SLOT_BR      = slot_br(DEF_NUM_ALU, DEF_NUM_MULT);

endpackage

// File: rtl/issue_scheduler_age_select.sv
// Oldest-entry picker: highest age wins, ties go to the lowest index.
module age_select import sys_defs::*; #(
  parameter int N  = 16,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]            mask_i,
  input  logic [N-1:0][AGE_W-1:0] age_i,
  output logic [IW-1:0]           idx_o,
  output logic                    found_o
);

  logic [AGE_W-1:0] best;

  // Linear scan; strict '>' keeps the earlier index on equal ages
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    best    = '0;
    for (int i = 0; i < N; i++) begin
      if (mask_i[i] && (!found_o || (age_i[i] > best))) begin
        found_o = 1'b1;
        best    = age_i[i];
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Issue scheduler: per-class oldest-first arbitration of ready RS entries
// onto ALU / LD / ST / MULT / BR slots, with multiplier occupancy tracking.
module issue_scheduler import sys_defs::*; #(
  parameter  int RS_SIZE  = 16,
  parameter  int NUM_ALU  = 3,
  parameter  int NUM_MULT = 2,
  parameter  int MULT_LAT = 4,
  localparam int N_FU     = num_fu(NUM_ALU, NUM_MULT),
  localparam int IDX_W    = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1,
  localparam int CNT_W    = $clog2(N_FU) + 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [RS_SIZE-1:0]                req_valid,
  input  logic [RS_SIZE-1:0][FU_W-1:0]      req_fu,
  input  logic [RS_SIZE-1:0][AGE_W-1:0]     req_age,
  input  logic [1:0]                        lsq_busy,
  input  logic                              squash,
  output logic [RS_SIZE-1:0]                issue_clear,
  output logic [N_FU-1:0]                   issue_valid,
  output logic [N_FU-1:0][IDX_W-1:0]        issue_idx,
  output logic [NUM_MULT-1:0]               mult_busy,
  output logic [CNT_W-1:0]                  issue_cnt
);

  localparam int S_LD  = slot_ld(NUM_ALU);
  localparam int S_ST  = slot_st(NUM_ALU);
  localparam int S_MUL = slot_mult(NUM_ALU);
  localparam int S_BR  = slot_br(NUM_ALU, NUM_MULT);

  logic kill;
  assign kill = reset | squash;

  logic [RS_SIZE-1:0] alu_cand, ld_cand, st_cand, mul_cand, br_cand;

  // Split ready entries into per-class candidate vectors
  always_comb begin
    alu_cand = '0;
    ld_cand  = '0;
    st_cand  = '0;
    mul_cand = '0;
    br_cand  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      alu_cand[i] = req_valid[i] && (req_fu[i] == FU_ALU);
      ld_cand[i]  = req_valid[i] && (req_fu[i] == FU_LD);
      st_cand[i]  = req_valid[i] && (req_fu[i] == FU_ST);
      mul_cand[i] = req_valid[i] && (req_fu[i] == FU_MULT);
      br_cand[i]  = req_valid[i] && (req_fu[i] == FU_BR);
    end
  end

  // ALU chain: each stage masks off the previous stage's winner
  logic [RS_SIZE-1:0] alu_mask [NUM_ALU+1];
  logic [IDX_W-1:0]   alu_idx  [NUM_ALU];
  logic [NUM_ALU-1:0] alu_fnd;

  assign alu_mask[0] = alu_cand;
  for (genvar k = 0; k < NUM_ALU; k++) begin : g_alu
    age_select #(.N(RS_SIZE), .IW(IDX_W)) u_sel (
      .mask_i (alu_mask[k]),
      .age_i  (req_age),
      .idx_o  (alu_idx[k]),
      .found_o(alu_fnd[k])
    );
    assign alu_mask[k+1] = alu_mask[k] &
                           ~({RS_SIZE{alu_fnd[k]}} & (RS_SIZE'(1) << alu_idx[k]));
  end

  // Multiplier chain: a busy unit passes the candidate set through untouched,
  // so the oldest candidate lands on the lowest-numbered free unit.
  logic [RS_SIZE-1:0]  mul_mask [NUM_MULT+1];
  logic [IDX_W-1:0]    mul_idx  [NUM_MULT];
  logic [NUM_MULT-1:0] mul_fnd, mul_take;

  assign mul_mask[0] = mul_cand;
  for (genvar u = 0; u < NUM_MULT; u++) begin : g_mul
    age_select #(.N(RS_SIZE), .IW(IDX_W)) u_sel (
      .mask_i (mul_mask[u]),
      .age_i  (req_age),
      .idx_o  (mul_idx[u]),
      .found_o(mul_fnd[u])
    );
    assign mul_take[u]   = mul_fnd[u] & ~mult_busy[u];
    assign mul_mask[u+1] = mul_mask[u] &
                           ~({RS_SIZE{mul_take[u]}} & (RS_SIZE'(1) << mul_idx[u]));
  end

  // Single-slot classes
  logic [IDX_W-1:0] ld_idx, st_idx, br_idx;
  logic             ld_fnd, st_fnd, br_fnd;

  age_select #(.N(RS_SIZE), .IW(IDX_W)) u_ld (
    .mask_i(ld_cand), .age_i(req_age), .idx_o(ld_idx), .found_o(ld_fnd));
  age_select #(.N(RS_SIZE), .IW(IDX_W)) u_st (
    .mask_i(st_cand), .age_i(req_age), .idx_o(st_idx), .found_o(st_fnd));
  age_select #(.N(RS_SIZE), .IW(IDX_W)) u_br (
    .mask_i(br_cand), .age_i(req_age), .idx_o(br_idx), .found_o(br_fnd));

  logic [N_FU-1:0]            g_vld;
  logic [N_FU-1:0][IDX_W-1:0] g_idx;
  logic [RS_SIZE-1:0]         g_clr;
  logic [CNT_W-1:0]           g_cnt;

  // Assemble per-slot grants; reset/squash suppresses everything
  always_comb begin
    g_vld = '0;
    g_idx = '0;
    if (!kill) begin
      for (int k = 0; k < NUM_ALU; k++) begin
        g_vld[k] = alu_fnd[k];
        g_idx[k] = alu_fnd[k] ? alu_idx[k] : '0;
      end
      g_vld[S_LD] = ld_fnd & ~lsq_busy[0];
      g_idx[S_LD] = g_vld[S_LD] ? ld_idx : '0;
      g_vld[S_ST] = st_fnd & ~lsq_busy[1];
      g_idx[S_ST] = g_vld[S_ST] ? st_idx : '0;
      for (int u = 0; u < NUM_MULT; u++) begin
        g_vld[S_MUL+u] = mul_take[u];
        g_idx[S_MUL+u] = mul_take[u] ? mul_idx[u] : '0;
      end
      g_vld[S_BR] = br_fnd;
      g_idx[S_BR] = br_fnd ? br_idx : '0;
    end
  end

  // Clear mask and grant count derived from the slot grants
  always_comb begin
    g_clr = '0;
    g_cnt = '0;
    for (int s = 0; s < N_FU; s++) begin
      if (g_vld[s]) g_clr[g_idx[s]] = 1'b1;
      g_cnt = g_cnt + CNT_W'(g_vld[s]);
    end
  end

  assign issue_clear = g_clr;

  logic [N_FU-1:0]            issue_valid_q;
  logic [N_FU-1:0][IDX_W-1:0] issue_idx_q;
  logic [CNT_W-1:0]           issue_cnt_q;

  // Register this cycle's grants for the execute stage
  always_ff @(posedge clock) begin
    if (reset) begin
      issue_valid_q <= '0;
      issue_idx_q   <= '0;
      issue_cnt_q   <= '0;
    end else begin
      issue_valid_q <= g_vld;
      issue_idx_q   <= g_idx;
      issue_cnt_q   <= g_cnt;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_idx   = issue_idx_q;
  assign issue_cnt   = issue_cnt_q;

  // Occupancy: load MULT_LAT-1 on grant, count down, hold at zero
  logic [OCC_W-1:0] occ_q [NUM_MULT];
  logic [OCC_W-1:0] occ_d [NUM_MULT];

  // Next occupancy per unit; squash frees every unit
  always_comb begin
    for (int u = 0; u < NUM_MULT; u++) begin
      occ_d[u] = occ_q[u];
      if (squash)                occ_d[u] = '0;
      else if (mul_take[u])      occ_d[u] = OCC_W'(MULT_LAT - 1);
      else if (occ_q[u] != '0)   occ_d[u] = occ_q[u] - 1'b1;
    end
  end

  // Occupancy register
  always_ff @(posedge clock) begin
    for (int u = 0; u < NUM_MULT; u++) begin
      if (reset) occ_q[u] <= '0;
      else       occ_q[u] <= occ_d[u];
    end
  end

  for (genvar u = 0; u < NUM_MULT; u++) begin : g_busy
    assign mult_busy[u] = (occ_q[u] != '0);
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed scenarios plus randomized traffic
// checked against a sort-based reference model.
module tb_issue_scheduler;

  localparam int RS  = 16;
  localparam int NA  = 3;
  localparam int NM  = 2;
  localparam int LAT = 4;
  localparam int NFU = 8;
  localparam int IW  = 4;
  localparam int CW  = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 squash;
  logic [RS-1:0]        req_valid;
  logic [RS-1:0][2:0]   req_fu;
  logic [RS-1:0][3:0]   req_age;
  logic [1:0]           lsq_busy;
  logic [RS-1:0]        issue_clear;
  logic [NFU-1:0]       issue_valid;
  logic [NFU-1:0][IW-1:0] issue_idx;
  logic [NM-1:0]        mult_busy;
  logic [CW-1:0]        issue_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  issue_scheduler #(.RS_SIZE(RS), .NUM_ALU(NA), .NUM_MULT(NM), .MULT_LAT(LAT)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_fu     (req_fu),
    .req_age    (req_age),
    .lsq_busy   (lsq_busy),
    .squash     (squash),
    .issue_clear(issue_clear),
    .issue_valid(issue_valid),
    .issue_idx  (issue_idx),
    .mult_busy  (mult_busy),
    .issue_cnt  (issue_cnt)
  );

  // ---------------- reference model ----------------
  int                   cyc = 0;
  int                   mfree [NM];      // first cycle each multiplier accepts
  logic [RS-1:0]        m_clear;
  logic [NM-1:0]        m_busy;
  logic [NFU-1:0]       m_vld;
  logic [NFU-1:0][IW-1:0] m_idx;
  int                   m_cnt;

  task automatic do_grant(input int s, input int key);
    int i;
    i = 63 - (key % 64);
    m_vld[s]   = 1'b1;
    m_idx[s]   = IW'(i);
    m_clear[i] = 1'b1;
  endtask

  // Candidates are keyed age*64 + (63-idx) and sorted descending, so the
  // queue order is exactly "oldest first, lowest index on ties".
  task automatic model_eval();
    int q[$];
    int k;
    m_clear = '0; m_vld = '0; m_idx = '0;
    for (int u = 0; u < NM; u++) m_busy[u] = (cyc < mfree[u]);
    if (reset || squash) begin
      for (int u = 0; u < NM; u++) mfree[u] = cyc + 1;
    end else begin
      for (int c = 0; c < 5; c++) begin
        q.delete();
        for (int i = 0; i < RS; i++)
          if (req_valid[i] && int'(req_fu[i]) == c) q.push_back(int'(req_age[i]) * 64 + (63 - i));
        q.rsort();
        case (c)
          0: for (k = 0; k < NA && k < q.size(); k++) do_grant(k, q[k]);
          1: if (!lsq_busy[0] && q.size() > 0) do_grant(3, q[0]);
          2: if (!lsq_busy[1] && q.size() > 0) do_grant(4, q[0]);
          3: begin
            k = 0;
            for (int u = 0; u < NM; u++)
              if (!m_busy[u] && k < q.size()) begin
                do_grant(5 + u, q[k]);
                mfree[u] = cyc + LAT;
                k++;
              end
          end
          default: if (q.size() > 0) do_grant(7, q[0]);
        endcase
      end
    end
    m_cnt = $countones(m_vld);
  endtask

  task automatic edge_step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic tick();
    model_eval();
    edge_step();
  endtask

  task automatic clr_inputs();
    req_valid = '0; req_fu = '0; req_age = '0; lsq_busy = '0; squash = 1'b0;
  endtask

  task automatic set_req(input int i, input int f, input int a);
    req_valid[i] = 1'b1;
    req_fu[i]    = 3'(f);
    req_age[i]   = 4'(a);
  endtask

  task automatic idle(input int n);
    clr_inputs();
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    clr_inputs();
    set_req(1, 0, 7); set_req(2, 3, 2);
    @(posedge clock); #1;
    #1;
    n_cmp++; if (issue_clear !== '0) begin n_bad++; $display("FAIL reset_clear: got %h want 0", issue_clear); end
    n_cmp++; if (issue_valid !== '0) begin n_bad++; $display("FAIL reset_valid: got %h want 0", issue_valid); end
    n_cmp++; if (issue_idx !== '0) begin n_bad++; $display("FAIL reset_idx: got %h want 0", issue_idx); end
    n_cmp++; if (issue_cnt !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", issue_cnt); end
    n_cmp++; if (mult_busy !== '0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", mult_busy); end
    tick();
    reset = 1'b0;
    clr_inputs();
  endtask

  task automatic test_alu_order();
    clr_inputs();
    set_req(2, 0, 3); set_req(5, 0, 9); set_req(7, 0, 9); set_req(9, 0, 1);
    #1;
    // only three ALU slots, so the age-1 entry at idx 9 waits
    n_cmp++; if (issue_clear !== 16'h00A4) begin n_bad++; $display("FAIL alu_clear: got %h want 00a4", issue_clear); end
    tick();
    n_cmp++; if (issue_valid !== 8'h07) begin n_bad++; $display("FAIL alu_valid: got %h want 07", issue_valid); end
    n_cmp++; if (issue_idx[0] !== 4'd5 || issue_idx[1] !== 4'd7 || issue_idx[2] !== 4'd2) begin
      n_bad++; $display("FAIL alu_idx: got %0d,%0d,%0d want 5,7,2", issue_idx[0], issue_idx[1], issue_idx[2]); end
    n_cmp++; if (issue_cnt !== 4'd3) begin n_bad++; $display("FAIL alu_cnt: got %0d want 3", issue_cnt); end
    req_valid[2] = 1'b0; req_valid[5] = 1'b0; req_valid[7] = 1'b0;
    #1;
    n_cmp++; if (issue_clear !== 16'h0200) begin n_bad++; $display("FAIL alu_retry_clear: got %h want 0200", issue_clear); end
    tick();
    n_cmp++; if (issue_valid !== 8'h01 || issue_idx[0] !== 4'd9) begin
      n_bad++; $display("FAIL alu_retry: got v=%h idx0=%0d want v=01 idx0=9", issue_valid, issue_idx[0]); end
  endtask

  task automatic test_mult_occupancy();
    idle(2);
    set_req(0, 3, 5); set_req(1, 3, 4); set_req(2, 3, 3);
    #1;
    n_cmp++; if (issue_clear !== 16'h0003 || mult_busy !== 2'b00) begin
      n_bad++; $display("FAIL mul_c0: got clr=%h busy=%b want 0003/00", issue_clear, mult_busy); end
    tick();
    n_cmp++; if (issue_valid !== 8'h60 || issue_idx[5] !== 4'd0 || issue_idx[6] !== 4'd1) begin
      n_bad++; $display("FAIL mul_grant: got v=%h i5=%0d i6=%0d want 60/0/1", issue_valid, issue_idx[5], issue_idx[6]); end
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    for (int k = 1; k < 4; k++) begin
      #1;
      n_cmp++; if (mult_busy !== 2'b11 || issue_clear !== '0) begin
        n_bad++; $display("FAIL mul_wait c%0d: got busy=%b clr=%h want 11/0000", k, mult_busy, issue_clear); end
      tick();
    end
    #1;
    n_cmp++; if (mult_busy !== 2'b00 || issue_clear !== 16'h0004) begin
      n_bad++; $display("FAIL mul_c4: got busy=%b clr=%h want 00/0004", mult_busy, issue_clear); end
    tick();
    n_cmp++; if (issue_valid !== 8'h20 || issue_idx[5] !== 4'd2) begin
      n_bad++; $display("FAIL mul_regrant: got v=%h i5=%0d want 20/2", issue_valid, issue_idx[5]); end
    idle(4);
  endtask

  task automatic test_lsq_gate();
    clr_inputs();
    set_req(3, 1, 2); set_req(6, 2, 4);
    lsq_busy = 2'b11;
    #1;
    n_cmp++; if (issue_clear !== '0) begin n_bad++; $display("FAIL lsq_blocked: got %h want 0", issue_clear); end
    tick();
    n_cmp++; if (issue_valid !== '0) begin n_bad++; $display("FAIL lsq_blocked_v: got %h want 0", issue_valid); end
    lsq_busy = 2'b10;
    #1;
    n_cmp++; if (issue_clear !== 16'h0008) begin n_bad++; $display("FAIL ld_open: got %h want 0008", issue_clear); end
    tick();
    n_cmp++; if (issue_valid !== 8'h08 || issue_idx[3] !== 4'd3) begin
      n_bad++; $display("FAIL ld_slot: got v=%h i3=%0d want 08/3", issue_valid, issue_idx[3]); end
    req_valid[3] = 1'b0;
    lsq_busy = 2'b00;
    #1;
    n_cmp++; if (issue_clear !== 16'h0040) begin n_bad++; $display("FAIL st_open: got %h want 0040", issue_clear); end
    tick();
    n_cmp++; if (issue_valid !== 8'h10 || issue_idx[4] !== 4'd6) begin
      n_bad++; $display("FAIL st_slot: got v=%h i4=%0d want 10/6", issue_valid, issue_idx[4]); end
  endtask

  task automatic test_squash();
    idle(1);
    set_req(4, 3, 1);
    #1;
    n_cmp++; if (issue_clear !== 16'h0010) begin n_bad++; $display("FAIL sq_pre: got %h want 0010", issue_clear); end
    tick();
    req_valid[4] = 1'b0;
    set_req(8, 0, 2);
    squash = 1'b1;
    #1;
    n_cmp++; if (issue_clear !== '0 || mult_busy !== 2'b01) begin
      n_bad++; $display("FAIL sq_cycle: got clr=%h busy=%b want 0000/01", issue_clear, mult_busy); end
    tick();
    squash = 1'b0;
    n_cmp++; if (mult_busy !== 2'b00 || issue_valid !== '0) begin
      n_bad++; $display("FAIL sq_after: got busy=%b v=%h want 00/00", mult_busy, issue_valid); end
    idle(1);
  endtask

  task automatic test_all_classes();
    logic dup;
    idle(1);
    set_req(1, 0, $urandom_range(0, 15)); set_req(10, 0, $urandom_range(0, 15));
    set_req(3, 1, 4); set_req(6, 2, 9); set_req(11, 3, 2); set_req(14, 4, 0);
    #1;
    n_cmp++; if (issue_clear !== 16'h4C4A) begin n_bad++; $display("FAIL mix_clear: got %h want 4c4a", issue_clear); end
    tick();
    n_cmp++; if (issue_valid !== 8'hBB || issue_cnt !== 4'd6) begin
      n_bad++; $display("FAIL mix_slots: got v=%h cnt=%0d want bb/6", issue_valid, issue_cnt); end
    dup = 1'b0;
    for (int a = 0; a < NFU; a++)
      for (int b = a + 1; b < NFU; b++)
        if (issue_valid[a] && issue_valid[b] && issue_idx[a] == issue_idx[b]) dup = 1'b1;
    n_cmp++; if (dup !== 1'b0) begin n_bad++; $display("FAIL mix_dup: got repeated index, want none"); end
    idle(4);
  endtask

  task automatic test_reset_busy();
    clr_inputs();
    set_req(0, 0, 1); set_req(1, 0, 2); set_req(2, 0, 3); set_req(3, 1, 1);
    set_req(4, 2, 1); set_req(5, 3, 1); set_req(6, 3, 1); set_req(7, 4, 1);
    #1;
    n_cmp++; if (issue_clear !== 16'h00FF) begin n_bad++; $display("FAIL full_clear: got %h want 00ff", issue_clear); end
    tick();
    n_cmp++; if (issue_valid !== 8'hFF || issue_cnt !== 4'd8 || mult_busy !== 2'b11) begin
      n_bad++; $display("FAIL full_state: got v=%h cnt=%0d busy=%b want ff/8/11", issue_valid, issue_cnt, mult_busy); end
    reset = 1'b1;
    #1;
    n_cmp++; if (issue_clear !== '0) begin n_bad++; $display("FAIL rst_clear: got %h want 0", issue_clear); end
    tick();
    reset = 1'b0;
    n_cmp++; if (issue_valid !== '0 || issue_idx !== '0 || issue_cnt !== '0 || mult_busy !== '0) begin
      n_bad++; $display("FAIL rst_all: got v=%h idx=%h cnt=%0d busy=%b want all 0", issue_valid, issue_idx, issue_cnt, mult_busy); end
    clr_inputs();
  endtask

  task automatic test_random();
    int bad_before;
    for (int n = 0; n < 400; n++) begin
      req_valid = RS'($urandom);
      for (int i = 0; i < RS; i++) begin
        req_fu[i]  = 3'($urandom_range(0, 5));
        req_age[i] = 4'($urandom_range(0, 15));
      end
      lsq_busy = 2'($urandom_range(0, 3));
      squash   = ($urandom_range(0, 15) == 0);
      reset    = ($urandom_range(0, 39) == 0);
      #1;
      model_eval();
      bad_before = n_bad;
      n_cmp++; if (issue_clear !== m_clear) begin n_bad++; $display("FAIL rnd_clear c%0d: got %h want %h", cyc, issue_clear, m_clear); end
      n_cmp++; if (mult_busy !== m_busy) begin n_bad++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, mult_busy, m_busy); end
      edge_step();
      n_cmp++; if (issue_valid !== m_vld) begin n_bad++; $display("FAIL rnd_valid c%0d: got %h want %h", cyc, issue_valid, m_vld); end
      n_cmp++; if (issue_idx !== m_idx) begin n_bad++; $display("FAIL rnd_idx c%0d: got %h want %h", cyc, issue_idx, m_idx); end
      n_cmp++; if (int'(issue_cnt) !== m_cnt) begin n_bad++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", cyc, issue_cnt, m_cnt); end
      if (n_bad - bad_before > 0 && n_bad > 20) break;
    end
    reset = 1'b0;
    clr_inputs();
  endtask

  initial begin
    for (int u = 0; u < NM; u++) mfree[u] = 0;
    reset = 1'b0;
    clr_inputs();
    test_reset();
    test_alu_order();
    test_mult_occupancy();
    test_lsq_gate();
    test_squash();
    test_all_classes();
    test_reset_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
